// File: rtl/pixel_compositor_if.sv
// Pixel-stream bundle from the VGA timing/sprite generators into the compositor.
// The master side is the timing controller plus layer generators; the compositor is the slave.
interface pixel_compositor_if #(
   parameter int unsigned NUM_LAYERS = 8
);
   logic [9:0]               h_cnt;
   logic [9:0]               v_cnt;
   logic                     valid;
   logic                     hsync_in;
   logic                     vsync_in;
   logic                     game_state;
   logic [NUM_LAYERS-1:0]    layer_en;
   logic [12*NUM_LAYERS-1:0] layer_pixel;
   logic                     flash_trig;

   modport master (
      output h_cnt, v_cnt, valid, hsync_in, vsync_in,
             game_state, layer_en, layer_pixel, flash_trig
   );

   modport slave (
      input  h_cnt, v_cnt, valid, hsync_in, vsync_in,
             game_state, layer_en, layer_pixel, flash_trig
   );
endinterface

// File: rtl/pixel_compositor.sv
// Layered pixel compositor: priority layer select with mask/colour-key/blink,
// full-screen flash inversion, 2-stage registered output with matched syncs.
module pixel_compositor #(
   parameter int unsigned           NUM_LAYERS   = 8,
   parameter int unsigned           H_ACTIVE     = 640,
   parameter logic [11:0]           BG_COLOR     = 12'hfff,
   parameter logic [11:0]           KEY_COLOR    = 12'h0f0,
   parameter logic [NUM_LAYERS-1:0] IDLE_MASK    = '1,
   parameter logic [NUM_LAYERS-1:0] GAME_MASK    = '1,
   parameter logic [NUM_LAYERS-1:0] BLINK_MASK   = '0,
   parameter int unsigned           BLINK_LOG2   = 4,
   parameter int unsigned           FLASH_FRAMES = 6
) (
   input  logic              clk_25MHz,
   input  logic              rst_n,
   pixel_compositor_if.slave pix_in,
   output logic [3:0]        vgaRed,
   output logic [3:0]        vgaGreen,
   output logic [3:0]        vgaBlue,
   output logic              hsync_out,
   output logic              vsync_out,
   output logic              flash_active
);

   localparam logic [10:0] H_LIMIT    = 11'(H_ACTIVE);
   localparam logic [7:0]  FLASH_LOAD = 8'(FLASH_FRAMES);

   logic                  origin;
   logic                  origin_q;
   logic                  frame_tick;
   logic [BLINK_LOG2:0]   frame_cnt;
   logic                  blink_off;
   logic [7:0]            flash_cnt;
   logic [7:0]            flash_nxt;

   logic [NUM_LAYERS-1:0] layer_mask;
   logic [NUM_LAYERS-1:0] eligible;
   logic [11:0]           sel_nxt;
   logic                  vis_nxt;

   logic [11:0]           sel_q;
   logic                  vis_q;
   logic                  hsync_q;
   logic                  vsync_q;
   logic [11:0]           rgb_q;

   // One tick per frame: rising edge of the (0,0) compare.
   assign origin     = (pix_in.h_cnt == '0) && (pix_in.v_cnt == '0);
   assign frame_tick = origin && !origin_q;
   assign blink_off  = frame_cnt[BLINK_LOG2];

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         origin_q  <= 1'b0;
         frame_cnt <= '0;
      end else begin
         origin_q <= origin;
         if (frame_tick)
            frame_cnt <= frame_cnt + 1'b1;
      end
   end

   // A trigger reloads even on a tick cycle, so the full duration is always honoured.
   always_comb begin
      flash_nxt = flash_cnt;
      if (pix_in.flash_trig)
         flash_nxt = FLASH_LOAD;
      else if (frame_tick && (flash_cnt != '0))
         flash_nxt = flash_cnt - 8'd1;
   end

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         flash_cnt    <= '0;
         flash_active <= 1'b0;
      end else begin
         flash_cnt    <= flash_nxt;
         flash_active <= (flash_nxt != '0);
      end
   end

   always_comb begin
      layer_mask = pix_in.game_state ? GAME_MASK : IDLE_MASK;
      eligible   = '0;
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
         eligible[i] = pix_in.layer_en[i] && layer_mask[i] &&
                       (pix_in.layer_pixel[12*i +: 12] != KEY_COLOR) &&
                       !(BLINK_MASK[i] && blink_off);
      end
   end

   // Walk from the lowest priority upward so the lowest eligible index wins.
   always_comb begin
      sel_nxt = BG_COLOR;
      for (int unsigned i = NUM_LAYERS; i > 0; i--) begin
         if (eligible[i-1])
            sel_nxt = pix_in.layer_pixel[12*(i-1) +: 12];
      end
   end

   assign vis_nxt = pix_in.valid && ({1'b0, pix_in.h_cnt} < H_LIMIT);

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         sel_q   <= '0;
         vis_q   <= 1'b0;
         hsync_q <= 1'b0;
         vsync_q <= 1'b0;
      end else begin
         sel_q   <= sel_nxt;
         vis_q   <= vis_nxt;
         hsync_q <= pix_in.hsync_in;
         vsync_q <= pix_in.vsync_in;
      end
   end

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         rgb_q     <= '0;
         hsync_out <= 1'b0;
         vsync_out <= 1'b0;
      end else begin
         if (!vis_q)
            rgb_q <= '0;
         else if (flash_cnt != '0)
            rgb_q <= ~sel_q;
         else
            rgb_q <= sel_q;
         hsync_out <= hsync_q;
         vsync_out <= vsync_q;
      end
   end

   assign vgaRed   = rgb_q[11:8];
   assign vgaGreen = rgb_q[7:4];
   assign vgaBlue  = rgb_q[3:0];

endmodule
